exc_unit: RTL and testbench

- Parametrised exception/interrupt controller for the pipelined MIPS core.
- Accepts per-stage exception requests (overflow, reserved instruction, etc.) plus masked hardware interrupts and prioritises them. Lower source index is the older stage and has higher priority.
- Captures cause code and EPC, sequences a pipeline flush, and redirects fetch to the handler vector.
- Handles ERET (return to EPC) and counts exceptions dropped while EXL is set.

---
 rtl/exc_unit.sv | 161 ++++++++++++++++
 tb/tb_exc_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_unit.sv
// Exception / interrupt controller for the pipelined MIPS core.
// It picks the oldest synchronous exception, or else a masked interrupt, or
// else an ERET. It records the cause and EPC, holds flush for FLUSH_CYC
// cycles, then keeps the redirect up until fetch acknowledges it.
// Exceptions that arrive while a handler is already active are counted, not taken.
module exc_unit #(
    parameter int                NUM_SRC   = 4,
    parameter int                CODE_W    = 5,
    parameter int                ADDR_W    = 32,
    parameter int                NUM_INT   = 6,
    parameter int                INT_CODE  = 0,
    parameter logic [ADDR_W-1:0] VECTOR    = 32'h0000_0180,
    parameter int                FLUSH_CYC = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          src_req,
    input  logic [NUM_SRC*CODE_W-1:0]   src_code,
    input  logic [NUM_SRC*ADDR_W-1:0]   src_pc,
    input  logic [NUM_INT-1:0]          int_req,
    input  logic [NUM_INT-1:0]          int_mask,
    input  logic                        int_en,
    input  logic [ADDR_W-1:0]           int_pc,
    input  logic                        eret,
    input  logic                        ack,
    output logic                        flush,
    output logic                        redirect_valid,
    output logic [ADDR_W-1:0]           redirect_pc,
    output logic [CODE_W-1:0]           exc_code,
    output logic [ADDR_W-1:0]           epc,
    output logic                        exl,
    output logic                        busy,
    output logic [7:0]                  drop_cnt
);

    // The flush counter runs from 0 up to FLUSH_CYC-1.
    localparam int               CNT_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t              state_q;
    logic                kind_ret_q;      // 0: exception entry, 1: ERET return
    logic [CNT_W-1:0]    cnt_q;
    logic                flush_q;
    logic                redirect_valid_q;
    logic [ADDR_W-1:0]   redirect_pc_q;
    logic [CODE_W-1:0]   exc_code_q;
    logic [ADDR_W-1:0]   epc_q;
    logic                exl_q;
    logic [7:0]          drop_cnt_q;

    logic                src_hit_d;
    logic [CODE_W-1:0]   sel_code_d;
    logic [ADDR_W-1:0]   sel_pc_d;
    logic                int_take_d;
    logic [7:0]          drop_cnt_d;

    // The drop counter saturates at 255 and does not wrap.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Select the oldest requesting stage; scanning downward lets the lowest index win.
    always_comb begin
        src_hit_d  = 1'b0;
        sel_code_d = '0;
        sel_pc_d   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_req[i]) begin
                src_hit_d  = 1'b1;
                sel_code_d = src_code[i*CODE_W +: CODE_W];
                sel_pc_d   = src_pc[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign int_take_d = int_en & (|(int_req & int_mask));
    assign drop_cnt_d = sat_inc(drop_cnt_q);

    // Sequencer: capture and flush, then redirect and wait for the fetch ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            kind_ret_q       <= 1'b0;
            cnt_q            <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            exc_code_q       <= '0;
            epc_q            <= '0;
            exl_q            <= 1'b0;
            drop_cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!exl_q && src_hit_d) begin
                        exc_code_q <= sel_code_d;
                        epc_q      <= sel_pc_d;
                        exl_q      <= 1'b1;
                        kind_ret_q <= 1'b0;
                        cnt_q      <= '0;
                        flush_q    <= 1'b1;
                        state_q    <= S_FLUSH;
                    end else if (!exl_q && int_take_d) begin
                        exc_code_q <= CODE_W'(INT_CODE);
                        epc_q      <= int_pc;
                        exl_q      <= 1'b1;
                        kind_ret_q <= 1'b0;
                        cnt_q      <= '0;
                        flush_q    <= 1'b1;
                        state_q    <= S_FLUSH;
                    end else if (eret && exl_q) begin
                        exl_q      <= 1'b0;
                        kind_ret_q <= 1'b1;
                        cnt_q      <= '0;
                        flush_q    <= 1'b1;
                        state_q    <= S_FLUSH;
                    end
                    // A nested exception while in the handler is only counted.
                    if (exl_q && src_hit_d) begin
                        drop_cnt_q <= drop_cnt_d;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == CNT_LAST) begin
                        flush_q          <= 1'b0;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= kind_ret_q ? epc_q : VECTOR;
                        state_q          <= S_REDIRECT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_REDIRECT: begin
                    if (ack) begin
                        redirect_valid_q <= 1'b0;
                        state_q          <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign exc_code       = exc_code_q;
    assign epc            = epc_q;
    assign exl            = exl_q;
    assign busy           = (state_q != S_IDLE);
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_exc_unit.sv
// Testbench for exc_unit. Directed scenarios check literal values. A
// timeline model then checks every output on every cycle, including a
// long randomized run.
module tb_exc_unit;

    localparam int          NS  = 4;
    localparam int          CW  = 5;
    localparam int          AW  = 32;
    localparam int          NI  = 6;
    localparam int          FC  = 2;
    localparam logic [31:0] VEC = 32'h0000_0180;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_req;
    logic [NS*CW-1:0]  src_code;
    logic [NS*AW-1:0]  src_pc;
    logic [NI-1:0]     int_req;
    logic [NI-1:0]     int_mask;
    logic              int_en;
    logic [AW-1:0]     int_pc;
    logic              eret;
    logic              ack;
    logic              flush;
    logic              redirect_valid;
    logic [AW-1:0]     redirect_pc;
    logic [CW-1:0]     exc_code;
    logic [AW-1:0]     epc;
    logic              exl;
    logic              busy;
    logic [7:0]        drop_cnt;

    exc_unit dut (
        .clk            (clk),
        .rst            (rst),
        .src_req        (src_req),
        .src_code       (src_code),
        .src_pc         (src_pc),
        .int_req        (int_req),
        .int_mask       (int_mask),
        .int_en         (int_en),
        .int_pc         (int_pc),
        .eret           (eret),
        .ack            (ack),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_code       (exc_code),
        .epc            (epc),
        .exl            (exl),
        .busy           (busy),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model. m_age counts edges since the event was accepted; 0 means idle.
    int          m_age;
    bit          m_ret;
    bit          m_exl;
    bit          m_was;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    int          m_drop;
    int          m_first;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age = 0; m_ret = 0; m_exl = 0; m_code = '0; m_epc = '0; m_drop = 0;
        end else if (m_age == 0) begin
            m_was   = m_exl;
            m_first = -1;
            for (int k = 0; k < NS; k++) begin
                if (m_first < 0 && src_req[k]) m_first = k;
            end
            if (!m_exl && m_first >= 0) begin
                m_code = src_code[m_first*CW +: CW];
                m_epc  = src_pc[m_first*AW +: AW];
                m_exl  = 1; m_ret = 0; m_age = 1;
            end else if (!m_exl && int_en && ((int_req & int_mask) != 0)) begin
                m_code = 5'd0; m_epc = int_pc;
                m_exl  = 1; m_ret = 0; m_age = 1;
            end else if (eret && m_exl) begin
                m_exl = 0; m_ret = 1; m_age = 1;
            end
            if (m_was && m_first >= 0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end else if (m_age >= FC + 1 && ack) begin
            m_age = 0;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_flush", 64'(flush), 64'(m_age >= 1 && m_age <= FC));
            chk("m_redirect_valid", 64'(redirect_valid), 64'(m_age >= FC + 1));
            chk("m_busy", 64'(busy), 64'(m_age != 0));
            chk("m_exl", 64'(exl), 64'(m_exl));
            chk("m_exc_code", 64'(exc_code), 64'(m_code));
            chk("m_epc", 64'(epc), 64'(m_epc));
            chk("m_drop_cnt", 64'(drop_cnt), 64'(m_drop));
            if (m_age >= FC + 1)
                chk("m_redirect_pc", 64'(redirect_pc), 64'(m_ret ? m_epc : VEC));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the redirect, check its target, then acknowledge it.
    task automatic wait_rv(input logic [31:0] exp_pc);
        int n = 0;
        while (!redirect_valid && n < 20) begin
            step();
            n++;
        end
        chk("redirect_reached", 64'(redirect_valid), 64'd1);
        chk("redirect_pc", 64'(redirect_pc), 64'(exp_pc));
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("redirect_released", 64'(redirect_valid), 64'd0);
    endtask

    task automatic do_eret(input logic [31:0] exp_pc);
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("eret_exl_clear", 64'(exl), 64'd0);
        chk("eret_flush", 64'(flush), 64'd1);
        wait_rv(exp_pc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; src_req = '0; src_code = '0; src_pc = '0; int_req = '0; int_mask = '0;
        int_en = 1'b0; int_pc = '0; eret = 1'b0; ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_rv", 64'(redirect_valid), 64'd0);
        chk("rst_exl", 64'(exl), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        step();

        // Oldest of two requesting stages wins.
        src_code[1*CW +: CW] = 5'd12; src_pc[1*AW +: AW] = 32'h0040_0010;
        src_code[2*CW +: CW] = 5'd10; src_pc[2*AW +: AW] = 32'h0040_0090;
        src_req = 4'b0110;
        step();
        src_req = '0;
        chk("t1_code", 64'(exc_code), 64'd12);
        chk("t1_epc", 64'(epc), 64'h0040_0010);
        chk("t1_exl", 64'(exl), 64'd1);
        chk("t1_flush_c1", 64'(flush), 64'd1);
        step();
        chk("t1_flush_c2", 64'(flush), 64'd1);
        step();
        chk("t1_flush_off", 64'(flush), 64'd0);
        chk("t1_rv", 64'(redirect_valid), 64'd1);
        chk("t1_rpc", 64'(redirect_pc), 64'h180);
        // Delayed ack; a request during the redirect window must be ignored.
        src_req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            step();
            src_req = '0;
            chk("t1_hold_rv", 64'(redirect_valid), 64'd1);
            chk("t1_hold_rpc", 64'(redirect_pc), 64'h180);
            chk("t1_hold_drop", 64'(drop_cnt), 64'd0);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t1_idle", 64'(busy), 64'd0);

        // Nested requests while exl=1 are dropped and counted.
        for (int p = 0; p < 3; p++) begin
            src_req = 4'b0100;
            step();
            src_req = '0;
            chk("t2_no_flush", 64'(flush), 64'd0);
            step();
        end
        chk("t2_drop3", 64'(drop_cnt), 64'd3);

        // ERET returns to the recorded EPC.
        do_eret(32'h0040_0010);
        chk("t3_code_kept", 64'(exc_code), 64'd12);
        // ERET with exl=0 does nothing.
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("t4_no_busy", 64'(busy), 64'd0);
        chk("t4_no_flush", 64'(flush), 64'd0);

        // A synchronous exception beats a simultaneous interrupt.
        src_code[0*CW +: CW] = 5'd10; src_pc[0*AW +: AW] = 32'h0040_0100;
        int_req = 6'b000001; int_mask = 6'b000001; int_en = 1'b1; int_pc = 32'h0040_0020;
        src_req = 4'b0001;
        step();
        src_req = '0;
        chk("t5_code", 64'(exc_code), 64'd10);
        chk("t5_epc", 64'(epc), 64'h0040_0100);
        wait_rv(32'h180);
        step();
        chk("t5_int_blocked", 64'(busy), 64'd0);
        do_eret(32'h0040_0100);
        step();
        chk("t5_int_code", 64'(exc_code), 64'd0);
        chk("t5_int_epc", 64'(epc), 64'h0040_0020);
        chk("t5_int_exl", 64'(exl), 64'd1);
        wait_rv(32'h180);
        eret = 1'b1;
        step();
        eret = 1'b0;
        int_req = '0;
        wait_rv(32'h0040_0020);

        // Drop counter saturates.
        src_code[3*CW +: CW] = 5'd12; src_pc[3*AW +: AW] = 32'h0040_0300;
        src_req = 4'b1000;
        step();
        src_req = '0;
        wait_rv(32'h180);
        src_req = 4'b0001;
        repeat (300) step();
        src_req = '0;
        chk("t6_drop_sat", 64'(drop_cnt), 64'd255);
        do_eret(32'h0040_0300);

        // Asynchronous reset in the middle of a flush.
        src_req = 4'b0001;
        step();
        src_req = '0;
        #2 rst = 1'b1;
        #1;
        chk("t7_flush", 64'(flush), 64'd0);
        chk("t7_rv", 64'(redirect_valid), 64'd0);
        chk("t7_exl", 64'(exl), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_code", 64'(exc_code), 64'd0);
        chk("t7_epc", 64'(epc), 64'd0);
        chk("t7_rpc", 64'(redirect_pc), 64'd0);
        chk("t7_drop", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        src_req = 4'b0010;
        step();
        src_req = '0;
        chk("t7_after_code", 64'(exc_code), 64'd12);
        chk("t7_after_exl", 64'(exl), 64'd1);
        chk("t7_after_flush", 64'(flush), 64'd1);
        wait_rv(32'h180);
        do_eret(32'h0040_0010);

        // Randomized traffic checked by the model.
        for (int c = 0; c < 3000; c++) begin
            src_req  = ($urandom_range(0, 5) == 0) ? NS'($urandom) : '0;
            src_code = (NS*CW)'($urandom);
            src_pc   = {$urandom, $urandom, $urandom, $urandom};
            int_req  = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
            int_mask = NI'($urandom);
            int_en   = 1'($urandom);
            int_pc   = $urandom;
            eret     = ($urandom_range(0, 4) == 0);
            ack      = 1'($urandom);
            step();
        end
        src_req = '0; int_req = '0; eret = 1'b0; ack = 1'b1;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
